// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : timing constants and types shared by the VGA timing block
// Rev 1.0
// ============================================================================
package vga_timing_pkg;

  // 640x480@60 timing set, 25.175 MHz pixel rate
  localparam int unsigned C_H_ACTIVE = 640;
  localparam int unsigned C_H_FP     = 16;
  localparam int unsigned C_H_SYNC   = 96;
  localparam int unsigned C_H_BP     = 48;
  localparam int unsigned C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;

  localparam int unsigned C_V_ACTIVE = 480;
  localparam int unsigned C_V_FP     = 10;
  localparam int unsigned C_V_SYNC   = 2;
  localparam int unsigned C_V_BP     = 33;
  localparam int unsigned C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

  typedef logic [9:0] coord_t;
  typedef logic [9:0] frame_ctr_t;

  // Half-open window test lo <= v < hi, done in 32 bits so hi may equal 1024
  function automatic logic in_window(input coord_t v, input int unsigned lo,
                                     input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay.sv
`default_nettype none
// ============================================================================
// sync_delay_line : enable-qualified shift register; DEPTH=0 is a passthrough
// Rev 1.0
// ============================================================================
module sync_delay_line #(
  parameter int unsigned      WIDTH   = 2,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_passthrough
      assign o_q = i_d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_pipe [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= RST_VAL;
        end else if (i_en) begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : raster counters, blanking/sync timing, strobes, frame count
// Rev 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = C_H_ACTIVE,
  parameter int unsigned H_FP       = C_H_FP,
  parameter int unsigned H_SYNC     = C_H_SYNC,
  parameter int unsigned H_BP       = C_H_BP,
  parameter int unsigned V_ACTIVE   = C_V_ACTIVE,
  parameter int unsigned V_FP       = C_V_FP,
  parameter int unsigned V_SYNC     = C_V_SYNC,
  parameter int unsigned V_BP       = C_V_BP,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pix_en,
  output coord_t     o_x,
  output coord_t     o_y,
  output logic       o_frame_active,
  output logic       o_h_sync,
  output logic       o_v_sync,
  output logic       o_line_start,
  output logic       o_frame_start,
  output frame_ctr_t o_frame_ctr
);

  // Totals must stay <= 1024 so the last coordinate fits coord_t
  localparam int unsigned c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t      c_h_last   = coord_t'(c_h_total - 1);
  localparam coord_t      c_v_last   = coord_t'(c_v_total - 1);
  localparam int unsigned c_hs_start = H_ACTIVE + H_FP;
  localparam int unsigned c_hs_end   = c_hs_start + H_SYNC;
  localparam int unsigned c_vs_start = V_ACTIVE + V_FP;
  localparam int unsigned c_vs_end   = c_vs_start + V_SYNC;
  localparam logic [1:0]  c_sync_idle = {~HS_POL, ~VS_POL};

  coord_t     r_x, r_y;
  logic       r_active;
  logic [1:0] r_sync;
  logic       r_line_start, r_frame_start;
  frame_ctr_t r_frame_ctr;

  logic       w_x_wrap, w_y_wrap, w_frame_wrap;
  coord_t     w_x_nxt, w_y_nxt;
  logic       w_active_nxt;
  logic [1:0] w_sync_raw, w_sync_dly;

  assign w_x_wrap     = (r_x == c_h_last);
  assign w_y_wrap     = (r_y == c_v_last);
  assign w_frame_wrap = w_x_wrap && w_y_wrap;
  assign w_x_nxt      = w_x_wrap ? '0 : r_x + coord_t'(1);
  assign w_y_nxt      = !w_x_wrap ? r_y : (w_y_wrap ? '0 : r_y + coord_t'(1));

  // Decoded from the next coordinates so every registered output lines up with x/y
  assign w_active_nxt = (32'(w_x_nxt) < H_ACTIVE) && (32'(w_y_nxt) < V_ACTIVE);
  assign w_sync_raw[1] = in_window(w_x_nxt, c_hs_start, c_hs_end) ? HS_POL : ~HS_POL;
  assign w_sync_raw[0] = in_window(w_y_nxt, c_vs_start, c_vs_end) ? VS_POL : ~VS_POL;

  sync_delay_line #(
    .WIDTH   (2),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (c_sync_idle)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (i_pix_en),
    .i_d   (w_sync_raw),
    .o_q   (w_sync_dly)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_active      <= 1'b0;
      r_sync        <= c_sync_idle;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_ctr   <= '0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (i_pix_en) begin
        r_x           <= w_x_nxt;
        r_y           <= w_y_nxt;
        r_active      <= w_active_nxt;
        r_sync        <= w_sync_dly;
        r_line_start  <= w_x_wrap;
        r_frame_start <= w_frame_wrap;
        if (w_frame_wrap) r_frame_ctr <= r_frame_ctr + frame_ctr_t'(1);
      end
    end
  end

  assign o_x            = r_x;
  assign o_y            = r_y;
  assign o_frame_active = r_active;
  assign o_h_sync       = r_sync[1];
  assign o_v_sync       = r_sync[0];
  assign o_line_start   = r_line_start;
  assign o_frame_start  = r_frame_start;
  assign o_frame_ctr    = r_frame_ctr;

endmodule
`default_nettype wire
